// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter (round-robin or fixed priority), one access in flight at a time.
// Latency 3 cycles req-to-ack, grants 3 cycles apart; a losing port stalls by holding req until its own ack.
module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int RR = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [1:0]    mode0,
    input  logic [1:0]    mode1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_we,
    output logic [1:0]    mem_mode,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          gnt_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic          we;
        logic [1:0]    mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          bad;
    } txn_t;

    state_t        state;
    state_t        nextState;
    logic          lastGnt;
    logic          grantPort;
    logic          winner;
    logic          anyReq;
    txn_t          cur;
    txn_t          cand;
    logic          doneAck;
    logic          doneErr;
    logic [DW-1:0] doneRdata;

    // Misaligned half/word and the reserved size code are rejected, never reach memory.
    function automatic logic badAccess(input logic [1:0] mode, input logic [1:0] lowAddr);
        case (mode)
            2'b00:   return (lowAddr != 2'b00);
            2'b01:   return lowAddr[0];
            2'b10:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign anyReq = req0 | req1;

    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = (RR != 0) ? ~lastGnt : 1'b0;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        cand       = '0;
        cand.we    = winner ? we1    : we0;
        cand.mode  = winner ? mode1  : mode0;
        cand.addr  = winner ? addr1  : addr0;
        cand.wdata = winner ? wdata1 : wdata0;
        cand.bad   = badAccess(cand.mode, cand.addr[1:0]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyReq) nextState = ACCESS;
            ACCESS:  nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mem_we    = 1'b0;
        doneAck   = 1'b0;
        doneErr   = 1'b0;
        doneRdata = '0;
        case (state)
            ACCESS: mem_we = cur.we & ~cur.bad;
            DONE: begin
                doneAck = 1'b1;
                doneErr = cur.bad;
                if (!cur.we && !cur.bad) begin
                    doneRdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // The latched request doubles as the memory bus, so it holds its value between accesses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grantPort <= 1'b0;
            lastGnt   <= 1'b1;
            cur       <= '0;
        end else if (state == IDLE && anyReq) begin
            grantPort <= winner;
            lastGnt   <= winner;
            cur       <= cand;
        end
    end

    assign mem_addr  = cur.addr;
    assign mem_mode  = cur.mode;
    assign mem_wdata = cur.wdata;
    assign gnt_id    = grantPort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            ack0   <= doneAck & ~grantPort;
            ack1   <= doneAck &  grantPort;
            err0   <= doneErr & ~grantPort;
            err1   <= doneErr &  grantPort;
            rdata0 <= grantPort ? '0 : doneRdata;
            rdata1 <= grantPort ? doneRdata : '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized two-port run against a transaction-level model.
// A round-robin instance is fully checked; a fixed-priority instance shares the stimulus for priority checks.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req0, req1, we0, we1;
    logic [1:0]    mode0, mode1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic          ack0, ack1, err0, err1, memWe, busy, gntId;
    logic [DW-1:0] rdata0, rdata1, memWdata, memRdata;
    logic [1:0]    memMode;
    logic [AW-1:0] memAddr;

    logic          fpAck0, fpAck1, fpErr0, fpErr1, fpMemWe, fpBusy, fpGntId;
    logic [DW-1:0] fpRdata0, fpRdata1, fpMemWdata, fpMemRdata;
    logic [1:0]    fpMemMode;
    logic [AW-1:0] fpMemAddr;
    assign fpMemRdata = '0;

    int nTests = 0;
    int nFail  = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .RR(1)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .mode0(mode0), .mode1(mode1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
        .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(memWe), .mem_mode(memMode), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rdata(memRdata), .busy(busy), .gnt_id(gntId)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .RR(0)) dutFp (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .mode0(mode0), .mode1(mode1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .ack0(fpAck0), .ack1(fpAck1),
        .err0(fpErr0), .err1(fpErr1), .rdata0(fpRdata0), .rdata1(fpRdata1),
        .mem_we(fpMemWe), .mem_mode(fpMemMode), .mem_addr(fpMemAddr), .mem_wdata(fpMemWdata),
        .mem_rdata(fpMemRdata), .busy(fpBusy), .gnt_id(fpGntId)
    );

    // Memory behind the round-robin instance: synchronous read, data the cycle after the address.
    logic [DW-1:0] memStore [logic [AW-1:0]];
    always @(posedge clk) begin
        if (memWe) memStore[memAddr] = memWdata;
        memRdata <= memStore.exists(memAddr) ? memStore[memAddr] : '0;
    end

    // Transaction-level reference: a grant occupies the arbiter for three edges, ack on the third.
    int            mPhase;
    logic          mLastGnt, mPort, mWe, mBad;
    logic [1:0]    mMode;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mWdata, mRd;
    logic [DW-1:0] refMem [logic [AW-1:0]];
    logic          expAck0, expAck1, expErr0, expErr1, expMemWe, expBusy, expGnt;
    logic [DW-1:0] expRdata0, expRdata1;
    logic [AW-1:0] expAddr;
    logic [1:0]    expMode;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mPhase = 0; mLastGnt = 1'b1; mPort = 1'b0;
            expAck0 = 0; expAck1 = 0; expErr0 = 0; expErr1 = 0; expMemWe = 0;
            expBusy = 0; expGnt = 0; expRdata0 = '0; expRdata1 = '0;
        end else begin
            expAck0 = 0; expAck1 = 0; expErr0 = 0; expErr1 = 0; expMemWe = 0;
            expRdata0 = '0; expRdata1 = '0;
            if (mPhase == 0) begin
                if (req0 || req1) begin
                    mPort    = (req0 && req1) ? !mLastGnt : req1;
                    mLastGnt = mPort;
                    mWe      = mPort ? we1 : we0;
                    mMode    = mPort ? mode1 : mode0;
                    mAddr    = mPort ? addr1 : addr0;
                    mWdata   = mPort ? wdata1 : wdata0;
                    mBad     = (mMode == 2'd3) || (mMode == 2'd1 && mAddr[0]) ||
                               (mMode == 2'd0 && mAddr[1:0] != 2'd0);
                    expMemWe = mWe && !mBad;
                    expAddr  = mAddr;
                    expMode  = mMode;
                    if (expMemWe) refMem[mAddr] = mWdata;
                    mPhase = 1;
                end
            end else if (mPhase == 1) begin
                mPhase = 2;
            end else begin
                mRd = (!mWe && !mBad && refMem.exists(mAddr)) ? refMem[mAddr] : '0;
                if (mPort) begin expAck1 = 1; expErr1 = mBad; expRdata1 = mRd; end
                else       begin expAck0 = 1; expErr0 = mBad; expRdata0 = mRd; end
                mPhase = 0;
            end
            expBusy = (mPhase != 0);
            expGnt  = mPort;
        end
    end

    task automatic idleInputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; mode0 = 0; mode1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic randFields(output logic we, output logic [1:0] mode,
                              output logic [AW-1:0] addr, output logic [DW-1:0] wd);
        we   = 1'($urandom_range(0, 1));
        mode = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        addr = AW'(16'h0010 + 4 * $urandom_range(0, 5) +
                   (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0));
        wd   = $urandom;
    endtask

    task automatic test_reset();
        reset = 0;
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; mode0 = 0; mode1 = 0;
        addr0 = 16'h0040; addr1 = 16'h0044; wdata0 = $urandom; wdata1 = $urandom;
        repeat (3) @(negedge clk);
        nTests++;
        if ({ack0, ack1, err0, err1, memWe, busy, gntId} !== 7'b0) begin
            nFail++;
            $display("FAIL reset_ctrl: got %b, want 0000000", {ack0, ack1, err0, err1, memWe, busy, gntId});
        end
        nTests++;
        if ({rdata0, rdata1, memAddr, memMode, memWdata} !== '0) begin
            nFail++;
            $display("FAIL reset_data: got %h/%h/%h/%h/%h, want all 0", rdata0, rdata1, memAddr, memMode, memWdata);
        end
        nTests++;
        if ({fpAck0, fpAck1, fpErr0, fpErr1, fpMemWe, fpBusy, fpGntId, fpRdata0, fpRdata1,
             fpMemAddr, fpMemMode, fpMemWdata} !== '0) begin
            nFail++;
            $display("FAIL reset_fp: got nonzero outputs on fixed-priority instance, want all 0");
        end
        idleInputs();
        req0 = 1; addr0 = 16'h0000;
        reset = 1;
        @(negedge clk);
        nTests++;
        if (busy !== 1'b1 || gntId !== 1'b0) begin
            nFail++;
            $display("FAIL first_grant: busy=%b gnt=%b, want busy=1 gnt=0", busy, gntId);
        end
        repeat (2) @(negedge clk);
        nTests++;
        if (ack0 !== 1'b1) begin
            nFail++;
            $display("FAIL first_ack: ack0=%b, want 1", ack0);
        end
        req0 = 0;
    endtask

    task automatic test_word_write_read();
        int ackAt, weCount;
        logic [AW-1:0] weAddr;
        logic [DW-1:0] weData, gotRd;
        logic gotErr;
        for (int ph = 0; ph < 2; ph++) begin
            req0 = 1; we0 = (ph == 0); mode0 = 2'b00; addr0 = 16'h0010; wdata0 = 32'hDEADBEEF;
            ackAt = -1; weCount = 0; weAddr = '0; weData = '0; gotRd = '0; gotErr = 1'b1;
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                if (memWe) begin weCount++; weAddr = memAddr; weData = memWdata; end
                if (ack0 && ackAt < 0) begin
                    ackAt = c; gotRd = rdata0; gotErr = err0; req0 = 0;
                end
            end
            nTests++;
            if (ackAt != 3) begin
                nFail++;
                $display("FAIL wr_rd_latency ph%0d: ack at cycle %0d, want 3", ph, ackAt);
            end
            nTests++;
            if (gotErr !== 1'b0) begin
                nFail++;
                $display("FAIL wr_rd_err ph%0d: err0=%b, want 0", ph, gotErr);
            end
            nTests++;
            if (weCount != ((ph == 0) ? 1 : 0)) begin
                nFail++;
                $display("FAIL wr_rd_we ph%0d: mem_we cycles %0d, want %0d", ph, weCount, (ph == 0) ? 1 : 0);
            end
            nTests++;
            if (ph == 0 && {weAddr, weData} !== {16'h0010, 32'hDEADBEEF}) begin
                nFail++;
                $display("FAIL wr_bus: addr=%h data=%h, want 0010 deadbeef", weAddr, weData);
            end else if (ph == 1 && gotRd !== 32'hDEADBEEF) begin
                nFail++;
                $display("FAIL rd_data: rdata0=%h, want deadbeef", gotRd);
            end
        end
    endtask

    task automatic test_rr_alternation();
        int order[$];
        int fpCnt0, fpCnt1, overlap;
        @(negedge clk); reset = 0; idleInputs();
        @(negedge clk); reset = 1;
        req0 = 1; req1 = 1; addr0 = 16'h0100; addr1 = 16'h0200;
        fpCnt0 = 0; fpCnt1 = 0; overlap = 0;
        for (int c = 0; c < 20 && order.size() < 4; c++) begin
            @(negedge clk);
            if (ack0 && ack1) overlap++;
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
            if (fpAck0) fpCnt0++;
            if (fpAck1) fpCnt1++;
        end
        nTests++;
        if (order.size() != 4) begin
            nFail++;
            $display("FAIL rr_count: %0d acks, want 4", order.size());
        end
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            nTests++;
            if (order[i] != (i % 2)) begin
                nFail++;
                $display("FAIL rr_order[%0d]: port %0d, want %0d", i, order[i], i % 2);
            end
        end
        nTests++;
        if (overlap != 0) begin
            nFail++;
            $display("FAIL rr_overlap: %0d overlapping acks, want 0", overlap);
        end
        nTests++;
        if (fpCnt0 != 4 || fpCnt1 != 0) begin
            nFail++;
            $display("FAIL fp_priority: port0 acks %0d port1 acks %0d, want 4 and 0", fpCnt0, fpCnt1);
        end
    endtask

    task automatic test_fixed_priority();
        int firstAt, late0;
        req0 = 0;
        firstAt = -1; late0 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (fpAck0) late0++;
            if (fpAck1 && firstAt < 0) begin firstAt = c; req1 = 0; end
        end
        nTests++;
        if (firstAt != 3) begin
            nFail++;
            $display("FAIL fp_port1_served: ack1 at cycle %0d, want 3", firstAt);
        end
        nTests++;
        if (late0 != 0) begin
            nFail++;
            $display("FAIL fp_no_port0: %0d port0 acks after drop, want 0", late0);
        end
    endtask

    task automatic test_error_cases();
        logic [1:0] tMode[2] = '{2'b01, 2'b11};
        logic       tWe[2]   = '{1'b0, 1'b1};
        logic [AW-1:0] tAddr[2] = '{16'h0003, 16'h0040};
        int ackAt, weSeen;
        logic gotErr;
        logic [DW-1:0] gotRd;
        idleInputs();
        for (int k = 0; k < 2; k++) begin
            req1 = 1; we1 = tWe[k]; mode1 = tMode[k]; addr1 = tAddr[k]; wdata1 = $urandom;
            ackAt = -1; weSeen = 0; gotErr = 0; gotRd = '1;
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                if (memWe) weSeen++;
                if (ack1 && ackAt < 0) begin ackAt = c; gotErr = err1; gotRd = rdata1; req1 = 0; end
            end
            nTests++;
            if (ackAt != 3) begin
                nFail++;
                $display("FAIL err%0d_ack: ack1 at cycle %0d, want 3", k, ackAt);
            end
            nTests++;
            if (gotErr !== 1'b1) begin
                nFail++;
                $display("FAIL err%0d_flag: err1=%b, want 1", k, gotErr);
            end
            nTests++;
            if (gotRd !== '0) begin
                nFail++;
                $display("FAIL err%0d_rdata: rdata1=%h, want 0", k, gotRd);
            end
            nTests++;
            if (weSeen != 0) begin
                nFail++;
                $display("FAIL err%0d_we: mem_we cycles %0d, want 0", k, weSeen);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int seen, ackSeen, ackAt, weSeen;
        logic [DW-1:0] wd;
        wd = $urandom;
        req0 = 1; we0 = 1; mode0 = 2'b00; addr0 = 16'h0030; wdata0 = wd;
        seen = 0;
        for (int c = 0; c < 5 && seen == 0; c++) begin
            @(negedge clk);
            if (memWe) seen = 1;
        end
        nTests++;
        if (seen == 0) begin
            nFail++;
            $display("FAIL mid_reset_we_seen: mem_we never high, want high in ACCESS");
        end
        #1 reset = 0;
        #1;
        nTests++;
        if (memWe !== 1'b0 || busy !== 1'b0) begin
            nFail++;
            $display("FAIL mid_reset_async: mem_we=%b busy=%b, want 0 0", memWe, busy);
        end
        ackSeen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack0 || ack1) ackSeen++;
        end
        nTests++;
        if (ackSeen != 0) begin
            nFail++;
            $display("FAIL mid_reset_noack: %0d acks during reset, want 0", ackSeen);
        end
        reset = 1;
        ackAt = -1; weSeen = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (memWe && memAddr === 16'h0030 && memWdata === wd) weSeen++;
            if (ack0 && ackAt < 0) begin
                ackAt = c; req0 = 0;
                nTests++;
                if (err0 !== 1'b0) begin
                    nFail++;
                    $display("FAIL mid_reset_err: err0=%b, want 0", err0);
                end
            end
        end
        nTests++;
        if (ackAt != 3) begin
            nFail++;
            $display("FAIL mid_reset_reserve: ack0 at cycle %0d, want 3", ackAt);
        end
        nTests++;
        if (weSeen != 1) begin
            nFail++;
            $display("FAIL mid_reset_rewrite: %0d write cycles, want 1", weSeen);
        end
    endtask

    task automatic test_random();
        int issued[2], acked[2];
        bit stopIssue;
        issued = '{0, 0}; acked = '{0, 0};
        @(negedge clk); reset = 0; idleInputs();
        @(negedge clk); reset = 1;
        for (int c = 0; c < 460; c++) begin
            stopIssue = (c >= 400);
            @(negedge clk);
            nTests++;
            if ({ack0, ack1} !== {expAck0, expAck1}) begin
                nFail++;
                $display("FAIL rand_ack c%0d: got %b%b, want %b%b", c, ack0, ack1, expAck0, expAck1);
            end
            if (ack0 && expAck0) begin
                nTests++;
                if ({err0, rdata0} !== {expErr0, expRdata0}) begin
                    nFail++;
                    $display("FAIL rand_p0 c%0d: err=%b rdata=%h, want %b %h", c, err0, rdata0, expErr0, expRdata0);
                end
            end
            if (ack1 && expAck1) begin
                nTests++;
                if ({err1, rdata1} !== {expErr1, expRdata1}) begin
                    nFail++;
                    $display("FAIL rand_p1 c%0d: err=%b rdata=%h, want %b %h", c, err1, rdata1, expErr1, expRdata1);
                end
            end
            nTests++;
            if (memWe !== expMemWe) begin
                nFail++;
                $display("FAIL rand_we c%0d: mem_we=%b, want %b", c, memWe, expMemWe);
            end
            if (expMemWe) begin
                nTests++;
                if ({memAddr, memMode} !== {expAddr, expMode}) begin
                    nFail++;
                    $display("FAIL rand_bus c%0d: addr=%h mode=%0d, want %h %0d", c, memAddr, memMode, expAddr, expMode);
                end
            end
            nTests++;
            if (busy !== expBusy || (expBusy && gntId !== expGnt)) begin
                nFail++;
                $display("FAIL rand_busy c%0d: busy=%b gnt=%b, want %b %b", c, busy, gntId, expBusy, expGnt);
            end
            if (req0 && ack0) begin
                acked[0]++;
                if (stopIssue || $urandom_range(0, 1) == 0) req0 = 0;
                else begin randFields(we0, mode0, addr0, wdata0); issued[0]++; end
            end else if (!req0 && !stopIssue && $urandom_range(0, 2) == 0) begin
                req0 = 1; randFields(we0, mode0, addr0, wdata0); issued[0]++;
            end
            if (req1 && ack1) begin
                acked[1]++;
                if (stopIssue || $urandom_range(0, 1) == 0) req1 = 0;
                else begin randFields(we1, mode1, addr1, wdata1); issued[1]++; end
            end else if (!req1 && !stopIssue && $urandom_range(0, 2) == 0) begin
                req1 = 1; randFields(we1, mode1, addr1, wdata1); issued[1]++;
            end
        end
        for (int p = 0; p < 2; p++) begin
            nTests++;
            if (acked[p] != issued[p] || issued[p] == 0) begin
                nFail++;
                $display("FAIL rand_lossless p%0d: acked %0d, want issued %0d (nonzero)", p, acked[p], issued[p]);
            end
        end
    endtask

    initial begin
        idleInputs();
        test_reset();
        test_word_write_read();
        test_rr_alternation();
        test_fixed_priority();
        test_error_cases();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
